// File: rtl/bf_program_loader_pkg.sv
// rtl/bf_program_loader_pkg.sv - opcodes, loader error codes and FSM states for the BF program loader
package bf_program_loader_pkg;

   localparam logic [3:0] BF_END     = 4'd0;
   localparam logic [3:0] BF_INC     = 4'd1;
   localparam logic [3:0] BF_DEC     = 4'd2;
   localparam logic [3:0] BF_RIGHT   = 4'd3;
   localparam logic [3:0] BF_LEFT    = 4'd4;
   localparam logic [3:0] BF_LOOP    = 4'd5;
   localparam logic [3:0] BF_ENDLOOP = 4'd6;
   localparam logic [3:0] BF_OUT     = 4'd7;
   localparam logic [3:0] BF_IN      = 4'd8;

   localparam logic [1:0] ERR_NONE      = 2'd0;
   localparam logic [1:0] ERR_UNDERFLOW = 2'd1;
   localparam logic [1:0] ERR_UNCLOSED  = 2'd2;
   localparam logic [1:0] ERR_OVERFLOW  = 2'd3;

   typedef enum logic [2:0] {
      ST_ACCEPT = 3'd0,
      ST_WRITE  = 3'd1,
      ST_TERM   = 3'd2,
      ST_DONE   = 3'd3,
      ST_ERROR  = 3'd4
   } loader_state_e;

endpackage

// File: rtl/bf_char_encoder.sv
// rtl/bf_char_encoder.sv - combinational ASCII to BF opcode encoder; non-BF characters come out invalid
module bf_char_encoder
   import bf_program_loader_pkg::*;
(
   input  logic [7:0] char_i,
   output logic       valid_o,
   output logic [3:0] opcode_o
);

   always_comb begin
      valid_o  = 1'b1;
      opcode_o = BF_END;
      case (char_i)
         8'h2B:   opcode_o = BF_INC;
         8'h2D:   opcode_o = BF_DEC;
         8'h3E:   opcode_o = BF_RIGHT;
         8'h3C:   opcode_o = BF_LEFT;
         8'h5B:   opcode_o = BF_LOOP;
         8'h5D:   opcode_o = BF_ENDLOOP;
         8'h2E:   opcode_o = BF_OUT;
         8'h2C:   opcode_o = BF_IN;
         default: valid_o  = 1'b0;
      endcase
   end

endmodule

// File: rtl/bf_program_loader.sv
// rtl/bf_program_loader.sv - writes encoded BF program characters into program memory and terminates with END
module bf_program_loader
   import bf_program_loader_pkg::*;
#(
   parameter int PMAW  = 8,
   parameter int NESTW = 4
) (
   input  logic            clock_i,
   input  logic            reset_ni,
   input  logic [7:0]      char_in_i,
   input  logic            char_strobe_i,
   input  logic            finish_i,
   output logic [PMAW-1:0] pm_address_o,
   output logic [3:0]      pm_data_o,
   output logic            pm_wren_o,
   output logic            loading_o,
   output logic            pm_input_done_o,
   output logic            error_o,
   output logic [1:0]      error_code_o,
   output logic [PMAW-1:0] char_count_o
);

   localparam logic [PMAW-1:0]  LAST_ADDR = '1;
   localparam logic [NESTW-1:0] MAX_DEPTH = '1;

   logic [2:0]       strobe_sync_q;
   logic [2:0]       finish_sync_q;
   logic             char_pulse;
   logic             finish_pulse;
   logic             char_valid;
   logic [3:0]       char_opcode;

   loader_state_e    state_q;
   logic [PMAW-1:0]  addr_q;
   logic [3:0]       data_q;
   logic             wren_q;
   logic             loading_q;
   logic             done_q;
   logic             error_q;
   logic [1:0]       error_code_q;
   logic [PMAW-1:0]  count_q;
   logic [NESTW-1:0] depth_q;

   // Two flops of synchronisation, the third only remembers the previous level for edge detection
   always_ff @(posedge clock_i or negedge reset_ni) begin
      if (!reset_ni) begin
         strobe_sync_q <= '0;
         finish_sync_q <= '0;
      end else begin
         strobe_sync_q <= {strobe_sync_q[1:0], char_strobe_i};
         finish_sync_q <= {finish_sync_q[1:0], finish_i};
      end
   end

   assign char_pulse   = strobe_sync_q[1] & ~strobe_sync_q[2];
   assign finish_pulse = finish_sync_q[1] & ~finish_sync_q[2];

   bf_char_encoder u_encoder (
      .char_i   (char_in_i),
      .valid_o  (char_valid),
      .opcode_o (char_opcode)
   );

   always_ff @(posedge clock_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state_q      <= ST_ACCEPT;
         addr_q       <= '0;
         data_q       <= BF_END;
         wren_q       <= 1'b0;
         loading_q    <= 1'b1;
         done_q       <= 1'b0;
         error_q      <= 1'b0;
         error_code_q <= ERR_NONE;
         count_q      <= '0;
         depth_q      <= '0;
      end else begin
         case (state_q)
            ST_ACCEPT: begin
               if (char_pulse && char_valid) begin
                  if (char_opcode == BF_ENDLOOP && depth_q == '0) begin
                     state_q      <= ST_ERROR;
                     loading_q    <= 1'b0;
                     error_q      <= 1'b1;
                     error_code_q <= ERR_UNDERFLOW;
                  end else if ((char_opcode == BF_LOOP && depth_q == MAX_DEPTH) ||
                               count_q == LAST_ADDR) begin
                     // The last word is kept free so END always fits
                     state_q      <= ST_ERROR;
                     loading_q    <= 1'b0;
                     error_q      <= 1'b1;
                     error_code_q <= ERR_OVERFLOW;
                  end else begin
                     state_q <= ST_WRITE;
                     wren_q  <= 1'b1;
                     addr_q  <= count_q;
                     data_q  <= char_opcode;
                  end
               end else if (finish_pulse) begin
                  if (depth_q != '0) begin
                     state_q      <= ST_ERROR;
                     loading_q    <= 1'b0;
                     error_q      <= 1'b1;
                     error_code_q <= ERR_UNCLOSED;
                  end else begin
                     state_q <= ST_TERM;
                     wren_q  <= 1'b1;
                     addr_q  <= count_q;
                     data_q  <= BF_END;
                  end
               end
            end
            ST_WRITE: begin
               wren_q  <= 1'b0;
               count_q <= count_q + 1'b1;
               if (data_q == BF_LOOP) begin
                  depth_q <= depth_q + 1'b1;
               end else if (data_q == BF_ENDLOOP) begin
                  depth_q <= depth_q - 1'b1;
               end
               state_q <= ST_ACCEPT;
            end
            ST_TERM: begin
               wren_q    <= 1'b0;
               loading_q <= 1'b0;
               done_q    <= 1'b1;
               state_q   <= ST_DONE;
            end
            default: begin
               state_q <= state_q;
            end
         endcase
      end
   end

   assign pm_address_o    = addr_q;
   assign pm_data_o       = data_q;
   assign pm_wren_o       = wren_q;
   assign loading_o       = loading_q;
   assign pm_input_done_o = done_q;
   assign error_o         = error_q;
   assign error_code_o    = error_code_q;
   assign char_count_o    = count_q;

endmodule

// File: tb/tb_bf_program_loader.sv
// tb/tb_bf_program_loader.sv - self-checking bench for bf_program_loader with a small-memory configuration
module tb_bf_program_loader;

   localparam int PMAW  = 4;
   localparam int NESTW = 2;
   localparam int DEPTH = 1 << PMAW;
   localparam int MAXD  = (1 << NESTW) - 1;

   logic            clock = 1'b0;
   logic            reset_n = 1'b0;
   logic [7:0]      char_in = 8'h00;
   logic            char_strobe = 1'b0;
   logic            finish = 1'b0;
   logic [PMAW-1:0] pm_address;
   logic [3:0]      pm_data;
   logic            pm_wren;
   logic            loading;
   logic            pm_input_done;
   logic            error;
   logic [1:0]      error_code;
   logic [PMAW-1:0] char_count;

   int vectors = 0;
   int miscompares = 0;

   logic [3:0] wa_q[$];
   logic [3:0] wd_q[$];
   logic [3:0] exp_q[$];
   int         exp_code;
   bit         exp_done;
   int         exp_count;

   bf_program_loader #(.PMAW(PMAW), .NESTW(NESTW)) dut (
      .clock_i         (clock),
      .reset_ni        (reset_n),
      .char_in_i       (char_in),
      .char_strobe_i   (char_strobe),
      .finish_i        (finish),
      .pm_address_o    (pm_address),
      .pm_data_o       (pm_data),
      .pm_wren_o       (pm_wren),
      .loading_o       (loading),
      .pm_input_done_o (pm_input_done),
      .error_o         (error),
      .error_code_o    (error_code),
      .char_count_o    (char_count)
   );

   always #5 clock = ~clock;

   always @(negedge clock) begin
      if (reset_n && pm_wren) begin
         wa_q.push_back(pm_address);
         wd_q.push_back(pm_data);
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic do_reset();
      @(negedge clock);
      reset_n = 1'b0;
      char_strobe = 1'b0;
      finish = 1'b0;
      cyc(2);
      reset_n = 1'b1;
      cyc(2);
      wa_q.delete();
      wd_q.delete();
   endtask

   task automatic press(input byte c, input bit with_finish);
      @(negedge clock);
      char_in = c;
      char_strobe = 1'b1;
      finish = with_finish;
      cyc(3);
      char_strobe = 1'b0;
      finish = 1'b0;
      cyc(3);
   endtask

   task automatic press_str(input string s);
      for (int i = 0; i < s.len(); i++) press(s[i], 1'b0);
   endtask

   task automatic press_finish();
      @(negedge clock);
      finish = 1'b1;
      cyc(3);
      finish = 1'b0;
      cyc(3);
   endtask

   // Reference: walk the character list with a depth counter, in submission order
   task automatic model(input string prog);
      string tbl = "+-><[].,";
      int depth = 0;
      exp_q.delete();
      exp_code = 0;
      exp_done = 1'b0;
      exp_count = 0;
      for (int i = 0; i < prog.len(); i++) begin
         int op = 0;
         for (int j = 0; j < 8; j++) if (tbl[j] == prog[i]) op = j + 1;
         if (exp_code != 0 || op == 0) continue;
         if (op == 6 && depth == 0) exp_code = 1;
         else if (op == 5 && depth == MAXD) exp_code = 3;
         else if (exp_count == DEPTH - 1) exp_code = 3;
         else begin
            exp_q.push_back(4'(op));
            exp_count++;
            if (op == 5) depth++;
            if (op == 6) depth--;
         end
      end
      if (exp_code == 0) begin
         if (depth != 0) exp_code = 2;
         else begin
            exp_q.push_back(4'd0);
            exp_done = 1'b1;
         end
      end
   endtask

   task automatic test_reset();
      @(negedge clock);
      reset_n = 1'b0;
      #1;
      vectors++; if (pm_wren !== 1'b0 || loading !== 1'b1 || pm_input_done !== 1'b0)
         begin miscompares++; $display("FAIL reset_ctrl: wren=%b loading=%b done=%b required 0 1 0", pm_wren, loading, pm_input_done); end
      cyc(2);
      reset_n = 1'b1;
      cyc(2);
      vectors++; if (pm_address !== 4'd0 || pm_data !== 4'd0)
         begin miscompares++; $display("FAIL reset_addr_data: addr=%0d data=%0d required 0 0", pm_address, pm_data); end
      vectors++; if (error !== 1'b0 || error_code !== 2'd0 || char_count !== 4'd0)
         begin miscompares++; $display("FAIL reset_err_count: err=%b code=%0d count=%0d required 0 0 0", error, error_code, char_count); end
      vectors++; if (loading !== 1'b1 || pm_input_done !== 1'b0)
         begin miscompares++; $display("FAIL reset_released: loading=%b done=%b required 1 0", loading, pm_input_done); end
   endtask

   task automatic test_basic_program();
      logic [3:0] e[6] = '{4'd1, 4'd5, 4'd2, 4'd6, 4'd7, 4'd0};
      do_reset();
      press_str("+[-].");
      press_finish();
      vectors++; if (wd_q.size() != 6)
         begin miscompares++; $display("FAIL basic_nwrites: got %0d required 6", wd_q.size()); end
      for (int i = 0; i < wd_q.size() && i < 6; i++) begin
         vectors++; if (wd_q[i] !== e[i] || wa_q[i] !== 4'(i))
            begin miscompares++; $display("FAIL basic_word%0d: addr=%0d data=%0d required addr %0d data %0d", i, wa_q[i], wd_q[i], i, e[i]); end
      end
      vectors++; if (char_count !== 4'd5 || pm_input_done !== 1'b1 || loading !== 1'b0 || error !== 1'b0)
         begin miscompares++; $display("FAIL basic_status: count=%0d done=%b loading=%b err=%b required 5 1 0 0", char_count, pm_input_done, loading, error); end
      vectors++; if (pm_address !== 4'd5 || pm_data !== 4'd0)
         begin miscompares++; $display("FAIL basic_hold: addr=%0d data=%0d required 5 0", pm_address, pm_data); end
      press_str("++");
      vectors++; if (wd_q.size() != 6 || char_count !== 4'd5)
         begin miscompares++; $display("FAIL done_ignores: writes=%0d count=%0d required 6 5", wd_q.size(), char_count); end
   endtask

   task automatic test_ignored_char();
      do_reset();
      press_str("+a");
      vectors++; if (wd_q.size() != 1 || char_count !== 4'd1 || error !== 1'b0)
         begin miscompares++; $display("FAIL ignored_char: writes=%0d count=%0d err=%b required 1 1 0", wd_q.size(), char_count, error); end
      press_str("-");
      vectors++; if (wd_q.size() != 2 || wa_q[wa_q.size()-1] !== 4'd1 || wd_q[wd_q.size()-1] !== 4'd2)
         begin miscompares++; $display("FAIL after_ignored: writes=%0d required 2 with last at addr 1 data 2", wd_q.size()); end
   endtask

   task automatic test_underflow();
      do_reset();
      press_str("]");
      vectors++; if (error !== 1'b1 || error_code !== 2'd1 || wd_q.size() != 0 || loading !== 1'b0)
         begin miscompares++; $display("FAIL underflow: err=%b code=%0d writes=%0d loading=%b required 1 1 0 0", error, error_code, wd_q.size(), loading); end
      press_str("+");
      press_finish();
      vectors++; if (wd_q.size() != 0 || error_code !== 2'd1 || pm_input_done !== 1'b0)
         begin miscompares++; $display("FAIL underflow_sticky: writes=%0d code=%0d done=%b required 0 1 0", wd_q.size(), error_code, pm_input_done); end
   endtask

   task automatic test_unclosed();
      do_reset();
      press_str("[[");
      press_finish();
      vectors++; if (error_code !== 2'd2 || wd_q.size() != 2 || pm_input_done !== 1'b0 || error !== 1'b1)
         begin miscompares++; $display("FAIL unclosed: code=%0d writes=%0d done=%b err=%b required 2 2 0 1", error_code, wd_q.size(), pm_input_done, error); end
   endtask

   task automatic test_overflow();
      do_reset();
      press_str("++++++++++++++++");
      vectors++; if (error_code !== 2'd3 || wd_q.size() != 15 || char_count !== 4'd15)
         begin miscompares++; $display("FAIL pm_overflow: code=%0d writes=%0d count=%0d required 3 15 15", error_code, wd_q.size(), char_count); end
      vectors++; if (wd_q.size() == 0 || wa_q[wa_q.size()-1] !== 4'd14)
         begin miscompares++; $display("FAIL pm_overflow_last: last addr=%0d required 14", (wa_q.size() == 0) ? 0 : wa_q[wa_q.size()-1]); end
      do_reset();
      press_str("+++++++++++++++");
      press_finish();
      vectors++; if (wd_q.size() != 16 || wa_q[wa_q.size()-1] !== 4'd15 || wd_q[wd_q.size()-1] !== 4'd0)
         begin miscompares++; $display("FAIL full_end: writes=%0d required 16 with END at addr 15", wd_q.size()); end
      vectors++; if (pm_input_done !== 1'b1 || char_count !== 4'd15 || error !== 1'b0)
         begin miscompares++; $display("FAIL full_status: done=%b count=%0d err=%b required 1 15 0", pm_input_done, char_count, error); end
      do_reset();
      press_str("[[[[");
      vectors++; if (error_code !== 2'd3 || wd_q.size() != 3)
         begin miscompares++; $display("FAIL nest_overflow: code=%0d writes=%0d required 3 3", error_code, wd_q.size()); end
   endtask

   task automatic test_empty_and_simultaneous();
      do_reset();
      press_finish();
      vectors++; if (wd_q.size() != 1 || wa_q[0] !== 4'd0 || wd_q[0] !== 4'd0 || pm_input_done !== 1'b1 || char_count !== 4'd0)
         begin miscompares++; $display("FAIL empty_program: writes=%0d done=%b count=%0d required 1 1 0", wd_q.size(), pm_input_done, char_count); end
      do_reset();
      press(8'h2B, 1'b1);
      vectors++; if (wd_q.size() != 1 || loading !== 1'b1 || pm_input_done !== 1'b0)
         begin miscompares++; $display("FAIL char_beats_finish: writes=%0d loading=%b done=%b required 1 1 0", wd_q.size(), loading, pm_input_done); end
      press_finish();
      vectors++; if (wd_q.size() != 2 || wa_q[1] !== 4'd1 || wd_q[1] !== 4'd0 || pm_input_done !== 1'b1)
         begin miscompares++; $display("FAIL finish_after_both: writes=%0d done=%b required 2 1", wd_q.size(), pm_input_done); end
   endtask

   task automatic test_latency_glitch();
      do_reset();
      @(posedge clock);
      #2;
      char_in = 8'h2B;
      char_strobe = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(posedge clock);
         #1;
         vectors++; if (pm_wren !== (i == 2))
            begin miscompares++; $display("FAIL latency_k%0d: wren=%b required %b", i, pm_wren, (i == 2)); end
      end
      char_strobe = 1'b0;
      cyc(4);
      @(posedge clock);
      #2;
      char_strobe = 1'b1;
      #4;
      char_strobe = 1'b0;
      cyc(6);
      vectors++; if (wd_q.size() != 1 || char_count !== 4'd1)
         begin miscompares++; $display("FAIL glitch_ignored: writes=%0d count=%0d required 1 1", wd_q.size(), char_count); end
   endtask

   task automatic test_reset_mid_write();
      bit seen = 1'b0;
      do_reset();
      press_str("+>+");
      @(negedge clock);
      char_in = 8'h2D;
      char_strobe = 1'b1;
      for (int i = 0; i < 8 && !seen; i++) begin
         @(negedge clock);
         seen = pm_wren;
      end
      vectors++; if (!seen)
         begin miscompares++; $display("FAIL mid_write_wait: wren never rose within 8 cycles, required a write"); end
      reset_n = 1'b0;
      #1;
      vectors++; if (pm_wren !== 1'b0 || pm_address !== 4'd0 || pm_data !== 4'd0 || char_count !== 4'd0 || loading !== 1'b1)
         begin miscompares++; $display("FAIL mid_write_reset: wren=%b addr=%0d data=%0d count=%0d loading=%b required 0 0 0 0 1", pm_wren, pm_address, pm_data, char_count, loading); end
      char_strobe = 1'b0;
      cyc(2);
      reset_n = 1'b1;
      cyc(2);
      wa_q.delete();
      wd_q.delete();
      press_str("+");
      vectors++; if (wd_q.size() != 1 || wa_q[0] !== 4'd0 || wd_q[0] !== 4'd1 || char_count !== 4'd1)
         begin miscompares++; $display("FAIL after_reset_write: writes=%0d count=%0d required 1 write at addr 0, count 1", wd_q.size(), char_count); end
   endtask

   task automatic test_random();
      string alpha = "+-<>[].,a [+]]";
      for (int it = 0; it < 20; it++) begin
         string prog = "";
         int len = $urandom_range(0, 18);
         for (int i = 0; i < len; i++) prog = {prog, string'(alpha[$urandom_range(0, alpha.len() - 1)])};
         model(prog);
         do_reset();
         press_str(prog);
         press_finish();
         vectors++; if (wd_q.size() != exp_q.size())
            begin miscompares++; $display("FAIL rand%0d_nwrites: got %0d required %0d prog '%s'", it, wd_q.size(), exp_q.size(), prog); end
         for (int i = 0; i < wd_q.size() && i < exp_q.size(); i++) begin
            vectors++; if (wd_q[i] !== exp_q[i] || wa_q[i] !== 4'(i))
               begin miscompares++; $display("FAIL rand%0d_word%0d: addr=%0d data=%0d required addr %0d data %0d", it, i, wa_q[i], wd_q[i], i, exp_q[i]); end
         end
         vectors++; if (error_code !== 2'(exp_code) || pm_input_done !== exp_done || char_count !== 4'(exp_count) || loading !== 1'b0 || error !== (exp_code != 0))
            begin miscompares++; $display("FAIL rand%0d_status: code=%0d done=%b count=%0d loading=%b required %0d %b %0d 0 prog '%s'", it, error_code, pm_input_done, char_count, loading, exp_code, exp_done, exp_count, prog); end
      end
   endtask

   initial begin
      test_reset();
      test_basic_program();
      test_ignored_char();
      test_underflow();
      test_unclosed();
      test_overflow();
      test_empty_and_simultaneous();
      test_latency_glitch();
      test_reset_mid_write();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
